// File: rtl/out_uart_reporter.sv
// Captures every change of the upstream status byte into a small FIFO and sends each byte as a UART frame on tx.
// Build option: define OUT_UART_PARITY_EN for 8E1 frames (even parity bit between DATA and STOP).
module out_uart_reporter #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [7:0]                    data_in,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int LVL_W        = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

`ifdef OUT_UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic             push_req, push, pop, full;
   logic [7:0]       head;
`ifdef OUT_UART_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      push_req     = enable && (!prev_valid_q || (data_in != prev_q));
      full         = (level_q == LVL_FULL);
      pop          = (state_q == IDLE) && (level_q != '0);
      push         = push_req && (!full || pop);
      head         = mem_q[rd_ptr_q];
      prev_valid_d = enable;
      prev_d       = enable ? data_in : prev_q;
      overflow_d   = overflow_q || (push_req && full && !pop);
      mem_d        = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = data_in;
      end
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
`ifdef OUT_UART_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d   = START;
               shift_d   = head;
               cnt_d     = CNT_RELOAD;
               bit_idx_d = 3'd0;
`ifdef OUT_UART_PARITY_EN
               parity_d  = ^head;
`endif
            end
         end
         START: begin
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = CNT_RELOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               cnt_d = CNT_RELOAD;
               if (bit_idx_q == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`ifdef OUT_UART_PARITY_EN
         PARITY: begin
            if (cnt_q == '0) begin
               state_d = STOP;
               cnt_d   = CNT_RELOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
`endif
         STOP: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // tx is registered from the current state, so the line trails the FSM by one cycle.
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
`ifdef OUT_UART_PARITY_EN
         PARITY:  tx_d = parity_q;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE) || (level_d != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef OUT_UART_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         mem_q        <= mem_d;
`ifdef OUT_UART_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule
